// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: launches one RV32F op into the multi-cycle FPU, stalls the pipe until it finishes, and registers the writeback
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fpValid_i,
  input  logic [29:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rs3_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        fpuEnable_o,
  output logic [29:0] fpuInstr_o,
  output logic [31:0] fpuRs1_o,
  output logic [31:0] fpuRs2_o,
  output logic [31:0] fpuRs3_o,
  input  logic        fpuBusy_i,
  input  logic [31:0] fpuOut_i,
  output logic        wbValid_o,
  output logic [4:0]  wbRd_o,
  output logic [31:0] wbData_o,
  output logic        wbToInt_o,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;
  state_e state_q;
  logic kill_q, en_q, to_q, to_int_q, wb_to_int_q;
  logic [CNT_W-1:0] cnt_q;
  logic [29:0] instr_q;
  logic [31:0] rs1_q, rs2_q, rs3_q, wb_data_q;
  logic [4:0] rd_q, wb_rd_q;
  logic accept, to_int_d, result_ready, kill_d;
  always_comb begin
    accept = state_q == IDLE && fpValid_i && !flush_i;
    to_int_d = instr_i[4:2] == 3'b101 &&
               (instr_i[29:25] == 5'b10100 || instr_i[29:25] == 5'b11000 || instr_i[29:25] == 5'b11100);
    result_ready = state_q == WAIT && cnt_q != '0 && !fpuBusy_i;
    kill_d = kill_q || flush_i;
  end
  assign stall_o = accept || ((state_q == LAUNCH || state_q == WAIT) && !kill_q);
  assign wbValid_o = state_q == DONE && !flush_i;
  assign fpuEnable_o = en_q;
  assign fpuInstr_o = instr_q;
  assign fpuRs1_o = rs1_q;
  assign fpuRs2_o = rs2_q;
  assign fpuRs3_o = rs3_q;
  assign wbRd_o = wb_rd_q;
  assign wbData_o = wb_data_q;
  assign wbToInt_o = wb_to_int_q;
  assign timeout_o = to_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      kill_q <= 1'b0;
      en_q <= 1'b0;
      to_q <= 1'b0;
      cnt_q <= '0;
      instr_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
      rd_q <= '0;
      to_int_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      wb_to_int_q <= 1'b0;
    end else begin
      en_q <= 1'b0;
      to_q <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (accept) begin
            instr_q <= instr_i;
            rs1_q <= rs1_i;
            rs2_q <= rs2_i;
            rs3_q <= rs3_i;
            rd_q <= rd_i;
            to_int_q <= to_int_d;
            en_q <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q <= '0;
          kill_q <= kill_d;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          kill_q <= kill_d;
          if (result_ready) begin
            state_q <= kill_d ? IDLE : DONE;
            if (!kill_d) begin
              wb_data_q <= fpuOut_i;
              wb_rd_q <= rd_q;
              wb_to_int_q <= to_int_q;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            to_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
